// File: rtl/exception_trap_ctrl_pkg.sv
// Shared constants for the exception/trap controller: cause codes, FSM
// states, address-region decode and the mtval source selection rule.
package exception_trap_ctrl_pkg;

    // Data-width selectors: W = 1 << (XLEN + 4)
    localparam int XLEN_32B = 1;
    localparam int XLEN_64B = 2;

    // Exception cause codes (4 bits); NO_E marks "no exception"
    localparam logic [3:0] E_INSTR_ADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
    localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
    localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
    localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
    localparam logic [3:0] E_ECALL                 = 4'd11;
    localparam logic [3:0] E_SP_OUT_OF_RANGE       = 4'd14;
    localparam logic [3:0] NO_E                    = 4'd15;

    // Trap entry/return FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_ENTER   = 3'd2,
        ST_IN_TRAP = 3'd3,
        ST_RET     = 3'd4,
        ST_HALT    = 3'd5
    } trap_state_e;

    // i_pc_f[20:18] value that identifies the text region
    localparam logic [2:0] REGION_TEXT = 3'b010;

    // mret after an ecall resumes at the instruction after the ecall
    localparam int ECALL_RET_OFFSET = 4;

    // Where mtval comes from for a given cause
    typedef enum logic [1:0] {
        TVAL_PC,
        TVAL_ADDR,
        TVAL_ZERO
    } tval_src_e;

    function automatic tval_src_e tval_source(input logic [3:0] code);
        case (code)
            E_INSTR_ADDR_MISALIGNED,
            E_ILLEGAL_INSTR:         return TVAL_PC;
            E_LOAD_ADDR_MISALIGNED,
            E_LOAD_ACCESS_FAULT,
            E_STORE_ADDR_MISALIGNED,
            E_STORE_ACCESS_FAULT:    return TVAL_ADDR;
            default:                 return TVAL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/exception_trap_ctrl_trap_ctx_stack.sv
// LIFO of trap contexts {pc, cause, tval}. The top entry is shown
// continuously; an empty stack shows zeros and NO_E.
module trap_ctx_stack
    import exception_trap_ctrl_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_pc,
    input  logic [3:0]   i_cause,
    input  logic [W-1:0] i_tval,
    output logic         o_full,
    output logic         o_nonempty,
    output logic [W-1:0] o_top_pc,
    output logic [3:0]   o_top_cause,
    output logic [W-1:0] o_top_tval
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_nonempty;
    logic [W-1:0]  r_pc    [DEPTH];
    logic [3:0]    r_cause [DEPTH];
    logic [W-1:0]  r_tval  [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_nonempty = r_nonempty;
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && r_nonempty && !w_do_push;
    assign w_wr_idx   = IW'(r_count);
    assign w_top_idx  = IW'(r_count - CW'(1));

    // Next occupancy from push/pop requests
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_count_next = r_count;
        if (w_do_push)
            w_count_next = r_count + CW'(1);
        else if (w_do_pop)
            w_count_next = r_count - CW'(1);
    end

    // Occupancy counter with a registered non-empty flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_nonempty <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_nonempty <= (w_count_next != '0);
        end
    end

    // Context storage written on push
    // NOTE: storage is not reset; r_count gates every read, so stale entries are never visible.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_pc[w_wr_idx]    <= i_pc;
            r_cause[w_wr_idx] <= i_cause;
            r_tval[w_wr_idx]  <= i_tval;
        end
    end

    assign o_top_pc    = r_nonempty ? r_pc[w_top_idx]    : '0;
    assign o_top_cause = r_nonempty ? r_cause[w_top_idx] : NO_E;
    assign o_top_tval  = r_nonempty ? r_tval[w_top_idx]  : '0;

endmodule

// File: rtl/exception_trap_ctrl.sv
// Exception/trap controller: carries fetch exceptions to E, arbitrates them
// against E-stage exceptions, and sequences trap entry, nested traps,
// mret return and fatal halt.
module exception_trap_ctrl
    import exception_trap_ctrl_pkg::*;
#(
    parameter int XLEN        = XLEN_64B,
    parameter int CARRY_DEPTH = 2,
    parameter int NEST_DEPTH  = 2,
    parameter int VECTORED    = 0,
    localparam int W          = 1 << (XLEN + 4),
    parameter logic [W-1:0] TRAP_VEC_BASE = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_pc_f,
    input  logic [3:0]   i_exc_code_f,
    input  logic [3:0]   i_exc_code_e,
    input  logic [W-1:0] i_alu_out_e,
    input  logic         i_valid_e,
    input  logic         i_stall,
    input  logic         i_flush_d,
    input  logic         i_mret_e,
    output logic         o_flush,
    output logic         o_redirect_en,
    output logic [W-1:0] o_redirect_pc,
    output logic [W-1:0] o_mepc,
    output logic [W-1:0] o_mtval,
    output logic [3:0]   o_mcause,
    output logic         o_trap_permission,
    output logic         o_reset_permission,
    output logic         o_halt,
    output logic [2:0]   o_state
);

    localparam int E_IDX = CARRY_DEPTH - 1;

    logic [3:0]   r_code_pipe [CARRY_DEPTH];
    logic [W-1:0] r_pc_pipe   [CARRY_DEPTH];
    trap_state_e  r_state;
    logic         r_flush;
    logic         r_redirect_en;
    logic [W-1:0] r_redirect_pc;
    logic         r_halt;
    logic         r_reset_perm;

    logic         w_sample_en;
    logic [3:0]   w_carried_code;
    logic [W-1:0] w_carried_pc;
    logic [3:0]   w_eff_code;
    logic         w_exc;
    logic         w_mret_take;
    logic [W-1:0] w_push_tval;
    logic         w_full;
    logic         w_nonempty;
    logic [W-1:0] w_top_pc;
    logic [3:0]   w_top_cause;
    logic [W-1:0] w_top_tval;
    logic [W-1:0] w_vec_pc;
    logic [W-1:0] w_ret_pc;

    // Carry pipe: shift {code, pc} toward E, kill on flushes, hold on stall
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CARRY_DEPTH; i++) begin
                r_code_pipe[i] <= NO_E;
                r_pc_pipe[i]   <= '0;
            end
        end else if (r_flush) begin
            for (int i = 0; i < CARRY_DEPTH; i++)
                r_code_pipe[i] <= NO_E;
        end else if (!i_stall) begin
            // A branch flush also kills the entry that would move into E
            r_code_pipe[0] <= i_flush_d ? NO_E : i_exc_code_f;
            r_pc_pipe[0]   <= i_pc_f;
            for (int i = 1; i < CARRY_DEPTH; i++) begin
                r_code_pipe[i] <= i_flush_d ? NO_E : r_code_pipe[i-1];
                r_pc_pipe[i]   <= r_pc_pipe[i-1];
            end
        end else if (i_flush_d) begin
            for (int i = 0; i < E_IDX; i++)
                r_code_pipe[i] <= NO_E;
        end
    end

    assign w_carried_code = r_code_pipe[E_IDX];
    assign w_carried_pc   = r_pc_pipe[E_IDX];
    assign w_sample_en    = i_valid_e && !i_stall &&
                            (r_state == ST_IDLE || r_state == ST_IN_TRAP);

    // Carried fetch code wins; a bare mret outside a trap is illegal
    assign w_eff_code = (w_carried_code != NO_E) ? w_carried_code :
                        (i_exc_code_e == NO_E && i_mret_e && r_state == ST_IDLE) ?
                        E_ILLEGAL_INSTR : i_exc_code_e;
    assign w_exc       = w_sample_en && (w_eff_code != NO_E);
    assign w_mret_take = w_sample_en && !w_exc && i_mret_e && (r_state == ST_IN_TRAP);

    // mtval selection by cause
    always_comb begin
        w_push_tval = '0;
        case (tval_source(w_eff_code))
            TVAL_PC:   w_push_tval = w_carried_pc;
            TVAL_ADDR: w_push_tval = i_alu_out_e;
            default:   w_push_tval = '0;
        endcase
    end

    trap_ctx_stack #(
        .W     (W),
        .DEPTH (NEST_DEPTH)
    ) u_stack (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_exc && !w_full),
        .i_pop       (w_mret_take),
        .i_pc        (w_carried_pc),
        .i_cause     (w_eff_code),
        .i_tval      (w_push_tval),
        .o_full      (w_full),
        .o_nonempty  (w_nonempty),
        .o_top_pc    (w_top_pc),
        .o_top_cause (w_top_cause),
        .o_top_tval  (w_top_tval)
    );

    assign w_vec_pc = TRAP_VEC_BASE + ((VECTORED != 0) ? (W'(w_top_cause) << 2) : '0);
    assign w_ret_pc = w_top_pc + ((w_top_cause == E_ECALL) ? W'(ECALL_RET_OFFSET) : '0);

    // Trap FSM with registered flush/redirect/halt outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_flush       <= 1'b0;
            r_redirect_en <= 1'b0;
            r_redirect_pc <= '0;
            r_halt        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
            r_flush       <= 1'b0;
            r_redirect_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_exc) begin
                        r_state <= ST_FLUSH;
                        r_flush <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state       <= ST_ENTER;
                    r_redirect_en <= 1'b1;
                    r_redirect_pc <= w_vec_pc;
                end
                ST_ENTER: r_state <= ST_IN_TRAP;
                ST_IN_TRAP: begin
                    if (w_exc) begin
                        r_state <= w_full ? ST_HALT : ST_FLUSH;
                        r_halt  <= w_full;
                        r_flush <= 1'b1;
                    end else if (w_mret_take) begin
                        r_state       <= ST_RET;
                        r_flush       <= 1'b1;
                        r_redirect_en <= 1'b1;
                        r_redirect_pc <= w_ret_pc;
                    end
                end
                ST_RET:  r_state <= w_nonempty ? ST_IN_TRAP : ST_IDLE;
                ST_HALT: begin
                    r_halt  <= 1'b1;
                    r_flush <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reset-region permission drops once fetch reaches the text region
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_reset_perm <= 1'b1;
        else if (i_pc_f[20:18] == REGION_TEXT)
            r_reset_perm <= 1'b0;
    end

    assign o_flush            = r_flush;
    assign o_redirect_en      = r_redirect_en;
    assign o_redirect_pc      = r_redirect_pc;
    assign o_mepc             = w_top_pc;
    assign o_mcause           = w_top_cause;
    assign o_mtval            = w_top_tval;
    assign o_trap_permission  = w_nonempty;
    assign o_reset_permission = r_reset_perm;
    assign o_halt             = r_halt;
    assign o_state            = r_state;

endmodule

// File: tb/tb_exception_trap_ctrl.sv
// Self-checking bench for exception_trap_ctrl: directed scenarios followed
// by random single-trap transactions against a cause-rule reference model.
module tb_exception_trap_ctrl;
    import exception_trap_ctrl_pkg::*;

    localparam logic [63:0] VEC_BASE = 64'h1000;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc_f;
    logic [3:0]  exc_f;
    logic [3:0]  exc_e;
    logic [63:0] alu;
    logic        valid_e;
    logic        stall;
    logic        flush_d;
    logic        mret;
    logic        o_flush;
    logic        o_redirect_en;
    logic [63:0] o_redirect_pc;
    logic [63:0] o_mepc;
    logic [63:0] o_mtval;
    logic [3:0]  o_mcause;
    logic        o_trap_permission;
    logic        o_reset_permission;
    logic        o_halt;
    logic [2:0]  o_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] f_codes [2] = '{E_INSTR_ADDR_MISALIGNED, E_ILLEGAL_INSTR};
    logic [3:0] e_codes [6] = '{E_LOAD_ADDR_MISALIGNED, E_LOAD_ACCESS_FAULT,
                                E_STORE_ADDR_MISALIGNED, E_STORE_ACCESS_FAULT,
                                E_ECALL, E_SP_OUT_OF_RANGE};

    exception_trap_ctrl #(
        .XLEN          (XLEN_64B),
        .CARRY_DEPTH   (2),
        .NEST_DEPTH    (2),
        .VECTORED      (1),
        .TRAP_VEC_BASE (VEC_BASE)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pc_f             (pc_f),
        .i_exc_code_f       (exc_f),
        .i_exc_code_e       (exc_e),
        .i_alu_out_e        (alu),
        .i_valid_e          (valid_e),
        .i_stall            (stall),
        .i_flush_d          (flush_d),
        .i_mret_e           (mret),
        .o_flush            (o_flush),
        .o_redirect_en      (o_redirect_en),
        .o_redirect_pc      (o_redirect_pc),
        .o_mepc             (o_mepc),
        .o_mtval            (o_mtval),
        .o_mcause           (o_mcause),
        .o_trap_permission  (o_trap_permission),
        .o_reset_permission (o_reset_permission),
        .o_halt             (o_halt),
        .o_state            (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (cause rules) ----------------
    function automatic logic [63:0] model_tval(logic [3:0] c, logic [63:0] pc, logic [63:0] a);
        if (c == E_INSTR_ADDR_MISALIGNED || c == E_ILLEGAL_INSTR) return pc;
        if (c inside {E_LOAD_ADDR_MISALIGNED, E_LOAD_ACCESS_FAULT,
                      E_STORE_ADDR_MISALIGNED, E_STORE_ACCESS_FAULT}) return a;
        return 64'h0;
    endfunction

    function automatic logic [63:0] model_vec(logic [3:0] c);
        return VEC_BASE + 64'(c) * 64'd4;
    endfunction

    function automatic logic [63:0] model_ret(logic [3:0] c, logic [63:0] pc);
        return pc + ((c == E_ECALL) ? 64'd4 : 64'd0);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".flush"},      64'(o_flush), 64'd0);
        check({tag, ".redir_en"},   64'(o_redirect_en), 64'd0);
        check({tag, ".redir_pc"},   o_redirect_pc, 64'd0);
        check({tag, ".mepc"},       o_mepc, 64'd0);
        check({tag, ".mtval"},      o_mtval, 64'd0);
        check({tag, ".mcause"},     64'(o_mcause), 64'(NO_E));
        check({tag, ".trap_perm"},  64'(o_trap_permission), 64'd0);
        check({tag, ".reset_perm"}, 64'(o_reset_permission), 64'd1);
        check({tag, ".halt"},       64'(o_halt), 64'd0);
        check({tag, ".state"},      64'(o_state), 64'(ST_IDLE));
    endtask

    // Put pc into the carry pipe with no fetch exception so it reaches E
    task automatic hold_pc(input logic [63:0] pc);
        pc_f  = pc;
        exc_f = NO_E;
        tick();
        tick();
    endtask

    // Drive a fetch exception; the last tick is the E-stage sampling edge
    task automatic fetch_exc(input logic [3:0] c, input logic [63:0] pc);
        pc_f  = pc;
        exc_f = c;
        tick();
        exc_f = NO_E;
        pc_f  = pc + 64'd4;
        tick();
        tick();
    endtask

    // Called right after the sampling edge: FLUSH then ENTER then IN_TRAP
    task automatic expect_trap(input string tag, input logic [3:0] c,
                               input logic [63:0] pc, input logic [63:0] tval);
        exc_e = NO_E;
        mret  = 1'b0;
        check({tag, ".flush_state"}, 64'(o_state), 64'(ST_FLUSH));
        check({tag, ".flush"},       64'(o_flush), 64'd1);
        check({tag, ".mepc"},        o_mepc, pc);
        check({tag, ".mcause"},      64'(o_mcause), 64'(c));
        check({tag, ".mtval"},       o_mtval, tval);
        check({tag, ".trap_perm"},   64'(o_trap_permission), 64'd1);
        tick();
        check({tag, ".enter_state"}, 64'(o_state), 64'(ST_ENTER));
        check({tag, ".redir_en"},    64'(o_redirect_en), 64'd1);
        check({tag, ".redir_pc"},    o_redirect_pc, model_vec(c));
        tick();
        check({tag, ".in_trap"},     64'(o_state), 64'(ST_IN_TRAP));
        check({tag, ".redir_off"},   64'(o_redirect_en), 64'd0);
    endtask

    task automatic do_ret(input string tag, input logic [63:0] ret_pc,
                          input logic [2:0] st_after, input logic perm_after);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check({tag, ".ret_state"}, 64'(o_state), 64'(ST_RET));
        check({tag, ".ret_flush"}, 64'(o_flush), 64'd1);
        check({tag, ".ret_en"},    64'(o_redirect_en), 64'd1);
        check({tag, ".ret_pc"},    o_redirect_pc, ret_pc);
        tick();
        check({tag, ".after_state"}, 64'(o_state), 64'(st_after));
        check({tag, ".after_perm"},  64'(o_trap_permission), 64'(perm_after));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  cf;
        logic [3:0]  ce;
        logic [3:0]  eff;
        logic [63:0] rpc;
        logic [63:0] ralu;

        rst_n   = 1'b0;
        pc_f    = 64'h0;
        exc_f   = NO_E;
        exc_e   = NO_E;
        alu     = 64'h0;
        valid_e = 1'b1;
        stall   = 1'b0;
        flush_d = 1'b0;
        mret    = 1'b0;

        #12;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;
        tick();
        check("reset_perm_low_pc", 64'(o_reset_permission), 64'd1);
        pc_f = 64'h80000;
        tick();
        check("reset_perm_text", 64'(o_reset_permission), 64'd0);

        // Illegal fetch carried two stages to E
        fetch_exc(E_ILLEGAL_INSTR, 64'h80010);
        expect_trap("illegal_fetch", E_ILLEGAL_INSTR, 64'h80010, 64'h80010);
        do_ret("illegal_ret", 64'h80010, ST_IDLE, 1'b0);

        // E-stage load misaligned, no carried code
        hold_pc(64'h80050);
        exc_e = E_LOAD_ADDR_MISALIGNED;
        alu   = 64'h140003;
        tick();
        expect_trap("load_mis", E_LOAD_ADDR_MISALIGNED, 64'h80050, 64'h140003);
        do_ret("load_mis_ret", 64'h80050, ST_IDLE, 1'b0);

        // Carried fetch code beats the E-stage code
        pc_f  = 64'h80090;
        exc_f = E_ILLEGAL_INSTR;
        tick();
        exc_f = NO_E;
        tick();
        exc_e = E_LOAD_ADDR_MISALIGNED;
        alu   = 64'h140003;
        tick();
        expect_trap("priority", E_ILLEGAL_INSTR, 64'h80090, 64'h80090);
        do_ret("priority_ret", 64'h80090, ST_IDLE, 1'b0);

        // Ecall returns past itself
        hold_pc(64'h80020);
        exc_e = E_ECALL;
        alu   = 64'h1234;
        tick();
        expect_trap("ecall", E_ECALL, 64'h80020, 64'h0);
        do_ret("ecall_ret", 64'h80024, ST_IDLE, 1'b0);

        // Stall holds a pending fetch exception in E
        pc_f  = 64'h80060;
        exc_f = E_ILLEGAL_INSTR;
        tick();
        exc_f = NO_E;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_trap", 64'(o_state), 64'(ST_IDLE));
        end
        stall = 1'b0;
        tick();
        expect_trap("stall_release", E_ILLEGAL_INSTR, 64'h80060, 64'h80060);
        do_ret("stall_ret", 64'h80060, ST_IDLE, 1'b0);

        // Branch flush kills the exception while it sits in D
        pc_f  = 64'h80070;
        exc_f = E_ILLEGAL_INSTR;
        tick();
        exc_f   = NO_E;
        flush_d = 1'b1;
        tick();
        flush_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_d_no_trap", 64'(o_state), 64'(ST_IDLE));
            check("flush_d_no_flush", 64'(o_flush), 64'd0);
        end

        // mret outside a trap is an illegal instruction
        hold_pc(64'h80080);
        mret = 1'b1;
        tick();
        expect_trap("mret_idle", E_ILLEGAL_INSTR, 64'h80080, 64'h80080);
        do_ret("mret_idle_ret", 64'h80080, ST_IDLE, 1'b0);

        // Random single traps against the cause-rule model
        for (int t = 0; t < 24; t++) begin
            rpc  = {32'h0, $urandom() & 32'hffff_fffc};
            ralu = {$urandom(), $urandom()};
            cf   = ($urandom_range(0, 1) == 0) ? f_codes[$urandom_range(0, 1)] : NO_E;
            ce   = e_codes[$urandom_range(0, 5)];
            if (cf != NO_E && $urandom_range(0, 1) == 0) ce = NO_E;
            eff  = (cf != NO_E) ? cf : ce;
            if (cf != NO_E) begin
                pc_f  = rpc;
                exc_f = cf;
                tick();
                exc_f = NO_E;
                tick();
            end else begin
                hold_pc(rpc);
            end
            exc_e = ce;
            alu   = ralu;
            tick();
            expect_trap("rand", eff, rpc, model_tval(eff, rpc, ralu));
            do_ret("rand_ret", model_ret(eff, rpc), ST_IDLE, 1'b0);
        end

        // Nested trap, return to the outer trap, then overflow into HALT
        hold_pc(64'h80200);
        exc_e = E_ECALL;
        tick();
        expect_trap("outer", E_ECALL, 64'h80200, 64'h0);
        hold_pc(64'h80300);
        exc_e = E_LOAD_ACCESS_FAULT;
        alu   = 64'hdead0;
        mret  = 1'b1;
        tick();
        expect_trap("inner", E_LOAD_ACCESS_FAULT, 64'h80300, 64'hdead0);
        do_ret("inner_ret", 64'h80300, ST_IN_TRAP, 1'b1);
        check("outer_mepc_back", o_mepc, 64'h80200);
        hold_pc(64'h80310);
        exc_e = E_STORE_ACCESS_FAULT;
        alu   = 64'hbeef0;
        tick();
        expect_trap("inner2", E_STORE_ACCESS_FAULT, 64'h80310, 64'hbeef0);
        hold_pc(64'h80400);
        exc_e = E_STORE_ADDR_MISALIGNED;
        tick();
        exc_e = NO_E;
        check("overflow_state", 64'(o_state), 64'(ST_HALT));
        check("overflow_halt", 64'(o_halt), 64'd1);
        check("overflow_flush", 64'(o_flush), 64'd1);
        check("overflow_mepc", o_mepc, 64'h80310);
        mret  = 1'b1;
        exc_e = E_ECALL;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_sticky", 64'(o_halt), 64'd1);
            check("halt_state", 64'(o_state), 64'(ST_HALT));
        end
        mret  = 1'b0;
        exc_e = NO_E;
        pc_f  = 64'h0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("halt_reset");
        #2 rst_n = 1'b1;

        // Reset asserted during ENTER discards the trap immediately
        fetch_exc(E_INSTR_ADDR_MISALIGNED, 64'h40);
        expect_trap("pre_reset", E_INSTR_ADDR_MISALIGNED, 64'h40, 64'h40);
        do_ret("pre_reset_ret", 64'h40, ST_IDLE, 1'b0);
        fetch_exc(E_INSTR_ADDR_MISALIGNED, 64'h80040);
        tick();
        check("enter_before_reset", 64'(o_state), 64'(ST_ENTER));
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("enter_reset");
        #2 rst_n = 1'b1;
        pc_f = 64'h0;
        tick();
        check("post_reset_idle", 64'(o_state), 64'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exception_trap_ctrl.md
Name: exception_trap_ctrl

Overview:
- Sequential successor to the combinational exception-signal decoder; sits beside the hazard unit and CSR file.
- Carries each fetch-stage exception code and PC down the pipeline alongside its instruction to E, and arbitrates it against E-stage exceptions.
- Runs the trap entry/return FSM and drives flush/redirect plus mepc/mcause/mtval.
- Supports a parametrised nested-trap context stack, vectored or direct trap dispatch, and fatal-halt on overflow.

Parameters:
- XLEN, `XLEN_64b: width selector; data width W = 1<<(XLEN+4).
- CARRY_DEPTH, 2: number of stage registers between F and E carrying {code, pc}.
- NEST_DEPTH, 2: trap context stack entries; 1 means any exception inside a trap halts.
- VECTORED, 0: 0 = redirect to TRAP_VEC_BASE; 1 = redirect to TRAP_VEC_BASE + 4*cause.
- TRAP_VEC_BASE, 0: trap vector base address (W bits).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pc_f  in  W  fetch PC
- i_exc_code_f  in  4  fetch exception code (`E_*/`NO_E)
- i_exc_code_e  in  4  execute exception code
- i_alu_out_e  in  W  E-stage address, used for mtval
- i_valid_e  in  1  E holds a real instruction
- i_stall  in  1  freeze carry pipe and E sampling
- i_flush_d  in  1  branch flush; kills carry entries younger than E
- i_mret_e  in  1  E instruction is mret
- o_flush  out  1  flush F/D/E
- o_redirect_en  out  1  PC redirect strobe
- o_redirect_pc  out  W  redirect target
- o_mepc, o_mtval  out  W  top-of-stack context
- o_mcause  out  4  top-of-stack cause
- o_trap_permission  out  1  stack non-empty
- o_reset_permission  out  1  reset region allowed
- o_halt  out  1  fatal, sticky
- o_state  out  3  FSM state, for debug

Behaviour:
- Reset (async, i_rst_n=0):
  - Outputs: o_flush=0, o_redirect_en=0, o_redirect_pc=0, o_mepc=0, o_mtval=0, o_mcause=`NO_E, o_trap_permission=0, o_reset_permission=1, o_halt=0.
  - Internal: carry pipe = `NO_E, stack empty, state IDLE.
  - Reset asserted mid-trap discards all context.
- Carry pipe:
  - Each !i_stall cycle shifts {i_exc_code_f, i_pc_f} one stage.
  - i_flush_d or o_flush writes `NO_E into all stages ahead of E; o_flush also clears the E-stage entry.
  - i_stall holds all stages.
- E sampling: occurs only when i_valid_e && !i_stall && state in {IDLE, IN_TRAP}.
  - Carried fetch code wins over i_exc_code_e.
  - Effective code `NO_E with i_mret_e in IDLE is promoted to `E_ILLEGAL_INSTR.
- mtval source by cause:
  - Fetch-misaligned or illegal: carried pc.
  - Load/store misaligned or fault: i_alu_out_e.
  - Ecall or SP-out-of-range: 0.
- FSM:
  - IDLE: exception at sample -> FLUSH (push context).
  - FLUSH (1 cycle): o_flush=1; pushed context visible on o_m* this cycle -> ENTER.
  - ENTER (1 cycle): o_redirect_en=1, o_redirect_pc = TRAP_VEC_BASE (+4*cause if VECTORED) -> IN_TRAP.
  - IN_TRAP, exception at sample: if the stack is full -> HALT; otherwise push -> FLUSH.
  - IN_TRAP, i_mret_e without exception: -> RET. Same-cycle exception and mret: exception wins.
  - RET (1 cycle): o_flush=1, o_redirect_en=1, o_redirect_pc = popped mepc (+4 if popped cause == `E_ECALL); pop.
  - RET exit: -> IN_TRAP if the stack is still non-empty, else IDLE.
  - HALT: o_halt=1, o_flush=1 held; exit only by reset.
- Exceptions presented during FLUSH/ENTER/RET are ignored, since they come from flushed instructions.
- Latency: exception sampled at T -> flush at T+1 -> redirect at T+2.
- o_reset_permission clears on the first cycle where i_pc_f[20:18] == 3'b010 (text region) and stays 0 until reset.
- o_trap_permission is registered: (stack count != 0).

Decomposition:
- Shared header Constants.vh holds:
  - `E_* codes and `NO_E;
  - state encodings ST_IDLE..ST_HALT;
  - region bit constants (text = 3'b010);
  - ecall return offset 4.
- Sub-module trap_ctx_stack: parametrised depth × {W pc, 4 cause, W tval} LIFO with push/pop/full/empty/top.
- Carry pipe and FSM stay in the top.

Test Plan:
- Illegal fetch at pc=0x80010: i_exc_code_f=`E_ILLEGAL_INSTR shifts 2 cycles to E. Required response:
  - o_flush at T+1 with o_mepc=0x80010, o_mtval=0x80010;
  - redirect to TRAP_VEC_BASE at T+2.
- Load misaligned with priority check: E code `E_LOAD_ADDR_MISALIGNED, alu_out=0x140003, carried code `NO_E -> mcause=`E_LOAD_ADDR_MISALIGNED, mtval=0x140003. Repeat with a carried fetch code present -> the fetch code wins.
- Ecall return: ecall at pc=0x80020, then mret in IN_TRAP -> RET redirect to 0x80024, stack empty, state IDLE, o_trap_permission=0.
- Nested overflow with NEST_DEPTH=2: trap, then a second exception inside -> push, o_mepc = inner pc. A third exception -> HALT, o_halt=1 sticky until i_rst_n low.
- Stall and branch flush:
  - i_stall=1 for 3 cycles with a pending fetch exception -> no trap until the stall releases.
  - i_flush_d=1 while the code is in D -> no trap at all.
- Reset handling:
  - mret in IDLE -> `E_ILLEGAL_INSTR trap.
  - Assert i_rst_n=0 during ENTER -> all outputs return to reset values immediately.
  - o_reset_permission drops once i_pc_f=0x80000.
